// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue path: default widths, opcode names
// and the issue FSM state encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_OPW   = 5;

  localparam logic [ALU_OPW-1:0] OP_08 = 5'b01000;
  localparam logic [ALU_OPW-1:0] OP_09 = 5'b01001;
  localparam logic [ALU_OPW-1:0] OP_0A = 5'b01010;
  localparam logic [ALU_OPW-1:0] OP_0B = 5'b01011;
  localparam logic [ALU_OPW-1:0] OP_0C = 5'b01100;
  localparam logic [ALU_OPW-1:0] OP_0D = 5'b01101;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } issue_state_e;

endpackage

// File: rtl/alu_req_fifo.sv
// Request buffer for the ALU issue controller: DEPTH entries, count-based full/empty,
// head visible combinationally on rdata.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DW    = ALU_OPW + 2 * ALU_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered requests to the ALU one at a time, waits the fixed ALU latency and
// holds the captured result on a valid/ready response port.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned OPW     = ALU_OPW,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OPW-1:0]   rsp_opcode,
  output logic [WIDTH-1:0] rsp_result
);

  localparam int unsigned DW   = OPW + 2 * WIDTH;
  localparam int unsigned CNTW = $clog2(ALU_LAT + 1);

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [DW-1:0]    fifo_rdata;
  logic [OPW-1:0]   head_op;
  logic [WIDTH-1:0] head_a, head_b;

  issue_state_e     state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0]   alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_enable_q, alu_enable_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [OPW-1:0]   rsp_opcode_q, rsp_opcode_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

  assign req_ready = !rst && !fifo_full;
  assign {head_op, head_a, head_b} = fifo_rdata;

  alu_req_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_req_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req_valid && req_ready),
    .wdata({req_opcode, req_a, req_b}),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_enable_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_result_d = rsp_result_q;
    fifo_pop     = 1'b0;
    case (state_q)
      StIdle:  fifo_pop = !fifo_empty;
      StIssue: begin
        cnt_d   = CNTW'(ALU_LAT);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CNTW'(1)) begin
          cnt_d        = '0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_out;
          rsp_opcode_d = alu_opcode_q;
          state_d      = StHold;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      StHold: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
          fifo_pop    = !fifo_empty;
        end
      end
      default: state_d = StIdle;
    endcase
    // Any pop, from idle or straight out of a completed handshake, starts a new issue.
    if (fifo_pop) begin
      alu_opcode_d = head_op;
      alu_a_d      = head_a;
      alu_b_d      = head_b;
      alu_enable_d = 1'b1;
      state_d      = StIssue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_enable_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_opcode_q <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_enable_q <= alu_enable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_enable = alu_enable_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_opcode = rsp_opcode_q;
  assign rsp_result = rsp_result_q;

endmodule
